// File: rtl/bank_deposit_controller_pkg.sv
// Shared constants, state encoding and box-count helper for the bank deposit controller.
// Optional feature macro: COMBO_BONUS_EN (consumed by bank_deposit_controller.sv).
package bank_deposit_controller_pkg;

    localparam int unsigned HEIGHT_W = 10;
    localparam int unsigned SCORE_W  = 14;

    localparam logic [HEIGHT_W-1:0] BASE_HEIGHT_DEF = 10'd30;
    localparam logic [SCORE_W-1:0]  SCORE_MAX_DEF   = 14'd9999;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DWELL  = 3'd1,
        ST_DROP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_EXIT   = 3'd4
    } state_t;

    // Boxes carried, derived from height by threshold compare (no divider).
    function automatic logic [1:0] boxes_held(input logic [HEIGHT_W-1:0] height,
                                              input logic [HEIGHT_W-1:0] base);
        logic [HEIGHT_W+1:0] h;
        logic [HEIGHT_W+1:0] two_base;
        logic [HEIGHT_W+1:0] three_base;
        h          = (HEIGHT_W+2)'(height);
        two_base   = (HEIGHT_W+2)'(base) << 1;
        three_base = two_base + (HEIGHT_W+2)'(base);
        if (h >= three_base)
            boxes_held = 2'd2;
        else if (h >= two_base)
            boxes_held = 2'd1;
        else
            boxes_held = 2'd0;
    endfunction

endpackage

// File: rtl/bank_deposit_controller_dwell_timer.sv
// Dwell timer: counts enabled cycles from a clear up to DWELL_CYCLES-1 and holds there.
module bank_deposit_controller_dwell_timer #(
    parameter int unsigned DWELL_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_done
);

    localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_terminal;

    assign w_at_terminal = (r_count == TERMINAL);
    assign o_done        = w_at_terminal;

    // Clear wins over count; counting stops at the terminal value.
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_en && !w_at_terminal)
            r_count <= r_count + CNT_W'(1);
    end

endmodule

// File: rtl/bank_deposit_controller.sv
// Bank deposit controller: drops one box per dwell period while the player is in the bank,
// confirms each drop from the height read back, and credits a saturating score.
// Optional feature macro: COMBO_BONUS_EN (second confirmed deposit of a visit earns a bonus).
module bank_deposit_controller
    import bank_deposit_controller_pkg::*;
#(
    parameter logic [HEIGHT_W-1:0] BASE_HEIGHT    = BASE_HEIGHT_DEF,
    parameter int unsigned         DWELL_CYCLES   = 25000000,
    parameter logic [SCORE_W-1:0]  POINTS_PER_BOX = 14'd1,
    parameter logic [SCORE_W-1:0]  SCORE_MAX      = SCORE_MAX_DEF
`ifdef COMBO_BONUS_EN
    ,
    parameter logic [SCORE_W-1:0]  BONUS_POINTS   = 14'd2
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                game_en,
    input  logic                player_in_bank,
    input  logic [HEIGHT_W-1:0] current_height,
    output logic                box_dropped_in,
    output logic [SCORE_W-1:0]  score,
    output logic                deposit_busy,
    output logic                deposit_done
);

    state_t              r_state;
    logic                r_drop;
    logic                r_done;
    logic                r_busy;
    logic [SCORE_W-1:0]  r_score;
    logic [HEIGHT_W-1:0] r_snap;

    logic [1:0]          w_held;
    logic                w_confirm;
    logic                w_timer_done;
    logic                w_timer_clear;
    logic                w_timer_en;
    logic [SCORE_W-1:0]  w_add;
    logic [SCORE_W:0]    w_sum;
    logic [SCORE_W-1:0]  w_score_next;

    assign w_held = boxes_held(current_height, BASE_HEIGHT);

    // A drop is confirmed when the height fell by exactly one box since the snapshot.
    assign w_confirm = ((HEIGHT_W+1)'(current_height) + (HEIGHT_W+1)'(BASE_HEIGHT))
                       == (HEIGHT_W+1)'(r_snap);

    // Timer restarts whenever we are outside DWELL, so each DWELL entry starts at zero.
    assign w_timer_clear = game_en && (r_state != ST_DWELL);
    assign w_timer_en    = game_en && (r_state == ST_DWELL);

    bank_deposit_controller_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_timer_clear),
        .i_en    (w_timer_en),
        .o_done  (w_timer_done)
    );

`ifdef COMBO_BONUS_EN
    logic [1:0] r_visit;

    // Counts confirmed deposits in the current bank visit; cleared whenever the visit ends.
    always_ff @(posedge clk) begin
        if (rst)
            r_visit <= 2'd0;
        else if (game_en) begin
            if ((r_state == ST_IDLE) ||
                ((r_state == ST_DWELL) && !player_in_bank) ||
                ((r_state == ST_EXIT) && !player_in_bank))
                r_visit <= 2'd0;
            else if ((r_state == ST_SETTLE) && w_confirm && (r_visit != 2'd3))
                r_visit <= r_visit + 2'd1;
        end
    end

    assign w_add = (r_visit == 2'd1) ? (POINTS_PER_BOX + BONUS_POINTS) : POINTS_PER_BOX;
`else
    assign w_add = POINTS_PER_BOX;
`endif

    // Saturating score add with one bit of headroom.
    assign w_sum        = (SCORE_W+1)'(r_score) + (SCORE_W+1)'(w_add);
    assign w_score_next = (w_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_MAX : w_sum[SCORE_W-1:0];

    // Deposit sequencing FSM; all state holds while game_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_score <= '0;
            r_snap  <= '0;
        end else if (game_en) begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (player_in_bank) begin
                        if (w_held != 2'd0) begin
                            r_state <= ST_DWELL;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_EXIT;
                        end
                    end
                end
                ST_DWELL: begin
                    if (!player_in_bank) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_timer_done) begin
                        r_state <= ST_DROP;
                        r_drop  <= 1'b1;
                    end
                end
                ST_DROP: begin
                    r_snap  <= current_height;
                    r_drop  <= 1'b0;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_confirm) begin
                        r_done  <= 1'b1;
                        r_score <= w_score_next;
                    end
                    if (player_in_bank && (w_held != 2'd0)) begin
                        r_state <= ST_DWELL;
                    end else if (player_in_bank) begin
                        r_state <= ST_EXIT;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_EXIT: begin
                    if (!player_in_bank)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_drop  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pulses are suppressed while the game is paused; they reappear on resume.
    assign box_dropped_in = r_drop & game_en;
    assign deposit_done   = r_done & game_en;
    assign score          = r_score;
    assign deposit_busy   = r_busy;

endmodule

// File: tb/tb_bank_deposit_controller.sv
// Bench for bank_deposit_controller: directed scenarios plus randomized traffic against a
// behavioural model, with a simple height manager answering the drop pulses.
// Honours COMBO_BONUS_EN the same way as the design.
module tb_bank_deposit_controller;

    localparam int DWELL = 4;
    localparam int BASE  = 30;
    localparam int PTS   = 1;
    localparam int BONUS = 2;
    localparam int SMAX  = 5;

    logic        clk;
    logic        rst;
    logic        game_en;
    logic        player_in_bank;
    logic [9:0]  current_height;
    logic        box_dropped_in;
    logic [13:0] score;
    logic        deposit_busy;
    logic        deposit_done;

    int n_tests;
    int n_fail;

    // Behavioural model state
    int m_count;
    bit m_drop;
    bit m_settle;
    bit m_parked;
    bit m_done;
    int m_snap;
    int m_score;
    int m_visit;

    bit last_drop;
    bit last_done;

    bank_deposit_controller #(
        .BASE_HEIGHT    (10'd30),
        .DWELL_CYCLES   (DWELL),
        .POINTS_PER_BOX (14'd1),
        .SCORE_MAX      (14'd5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .game_en        (game_en),
        .player_in_bank (player_in_bank),
        .current_height (current_height),
        .box_dropped_in (box_dropped_in),
        .score          (score),
        .deposit_busy   (deposit_busy),
        .deposit_done   (deposit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference behaviour, from inputs and the height seen before the edge.
    task automatic model_step(input bit ib, input bit ge, input bit rs, input int h);
        int held;
        int add;
        if (rs) begin
            m_count = 0; m_drop = 0; m_settle = 0; m_parked = 0;
            m_done = 0; m_snap = 0; m_score = 0; m_visit = 0;
            return;
        end
        if (!ge) return;
        held = h / BASE - 1;
        if (held < 0) held = 0;
        if (held > 2) held = 2;
        m_done = 0;
        if (m_drop) begin
            m_snap   = h;
            m_drop   = 0;
            m_settle = 1;
        end else if (m_settle) begin
            m_settle = 0;
            if (h + BASE == m_snap) begin
                m_done = 1;
                m_visit++;
                add = PTS;
`ifdef COMBO_BONUS_EN
                if (m_visit == 2) add += BONUS;
`endif
                m_score = (m_score + add > SMAX) ? SMAX : m_score + add;
            end
            if (ib && held > 0) m_count = DWELL;
            else if (ib) m_parked = 1;
        end else if (m_count > 0) begin
            if (!ib) begin
                m_count = 0;
                m_visit = 0;
            end else begin
                m_count--;
                if (m_count == 0) m_drop = 1;
            end
        end else if (m_parked) begin
            if (!ib) begin
                m_parked = 0;
                m_visit  = 0;
            end
        end else begin
            m_visit = 0;
            if (ib) begin
                if (held > 0) m_count = DWELL;
                else m_parked = 1;
            end
        end
    endtask

    // Drive one cycle from a negedge, compare outputs, advance model and height manager.
    task automatic step(input bit ib, input bit ge, input bit ct, input bit rf, input bit rs);
        int h_pre;
        bit drop_seen;
        player_in_bank = ib;
        game_en        = ge;
        rst            = rs;
        #1;
        drop_seen = box_dropped_in;
        check("box_dropped_in", int'(box_dropped_in), int'(m_drop && ge));
        check("deposit_done", int'(deposit_done), int'(m_done && ge));
        check("deposit_busy", int'(deposit_busy), int'(m_count > 0 || m_drop || m_settle));
        check("score", int'(score), m_score);
        last_drop = drop_seen;
        last_done = deposit_done;
        h_pre = int'(current_height);
        @(posedge clk);
        #1;
        model_step(ib, ge, rs, h_pre);
        if (ct)
            current_height = (h_pre + BASE > 150) ? 10'(h_pre) : 10'(h_pre + BASE);
        else if (drop_seen && !rf)
            current_height = (h_pre >= BASE) ? 10'(h_pre - BASE) : 10'd0;
        @(negedge clk);
    endtask

    initial begin
        int first_drop;
        int second_drop;
        int drops;
        int dones;
        int en_cycles;
        int frozen_drops;
        bit found;
        bit ib;
        bit ge;
        bit ct;
        bit rf;
        bit rs;

        n_tests = 0; n_fail = 0;
        m_count = 0; m_drop = 0; m_settle = 0; m_parked = 0;
        m_done = 0; m_snap = 0; m_score = 0; m_visit = 0;
        rst = 1'b1; game_en = 1'b0; player_in_bank = 1'b0; current_height = 10'd0;
        @(negedge clk);

        // Reset state
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        check("reset_score", int'(score), 0);
        check("reset_busy", int'(deposit_busy), 0);
        check("reset_drop", int'(box_dropped_in), 0);

        // Two boxes deposited in one visit
        current_height = 10'd90;
        first_drop = -1; second_drop = -1; dones = 0;
        for (int k = 0; k < 15; k++) begin
            step(1, 1, 0, 0, 0);
            if (last_drop) begin
                if (first_drop < 0) first_drop = k;
                else second_drop = k;
            end
            if (last_done) dones++;
        end
        check("two_drop_spacing", second_drop - first_drop, 6);
        check("two_drop_first", first_drop, 5);
        check("two_drop_height", int'(current_height), 30);
        check("two_drop_dones", dones, 2);
`ifdef COMBO_BONUS_EN
        check("two_drop_score", int'(score), 4);
`else
        check("two_drop_score", int'(score), 2);
`endif
        check("two_drop_exit_busy", int'(deposit_busy), 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Leaving during DWELL aborts without a drop
        step(0, 1, 0, 0, 1);
        current_height = 10'd60;
        drops = 0;
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 0);
            if (last_drop) drops++;
        end
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 0, 0);
            if (last_drop) drops++;
        end
        check("abort_drops", drops, 0);
        check("abort_score", int'(score), 0);
        check("abort_busy", int'(deposit_busy), 0);

        // Refused drop: no credit, controller re-arms
        current_height = 10'd60;
        drops = 0; dones = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 0, 1, 0);
            if (last_drop) drops++;
            if (last_done) dones++;
        end
        check("refuse_drops", drops, 1);
        check("refuse_dones", dones, 0);
        check("refuse_score", int'(score), 0);
        check("refuse_rearm_busy", int'(deposit_busy), 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Pause mid-DWELL freezes the timer
        step(0, 1, 0, 0, 1);
        current_height = 10'd60;
        step(1, 1, 0, 0, 0);
        en_cycles = 0; frozen_drops = 0; found = 0;
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 0, 0, 0);
            en_cycles++;
        end
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, 0, 0);
            if (last_drop) frozen_drops++;
        end
        for (int k = 0; k < 10 && !found; k++) begin
            step(1, 1, 0, 0, 0);
            if (last_drop) found = 1;
            else en_cycles++;
        end
        check("pause_drop_seen", int'(found), 1);
        check("pause_enabled_cycles", en_cycles, 4);
        check("pause_frozen_drops", frozen_drops, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);

        // Reset while a drop pulse is out
        current_height = 10'd90;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_drop) found = 1;
            else step(1, 1, 0, 0, 0);
        end
        check("rst_reach_drop", int'(found), 1);
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        check("rst_drop_low", int'(last_drop), 0);
        check("rst_score", int'(score), 0);
        check("rst_busy", int'(deposit_busy), 0);
        check("rst_done", int'(last_done), 0);

        // Score saturation: deposits at the ceiling still pulse done
        step(0, 1, 0, 0, 1);
        dones = 0;
        for (int v = 0; v < 3; v++) begin
            current_height = 10'd90;
            dones = 0;
            for (int k = 0; k < 15; k++) begin
                step(1, 1, 0, 0, 0);
                if (last_done) dones++;
            end
            step(0, 1, 0, 0, 0);
            step(0, 1, 0, 0, 0);
        end
        check("sat_score", int'(score), SMAX);
        check("sat_last_dones", dones, 2);

        // Randomized traffic against the model
        step(0, 1, 0, 0, 1);
        current_height = 10'd90;
        ib = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 11) == 0) ib = ~ib;
            ge = ($urandom_range(0, 9) != 0);
            ct = ($urandom_range(0, 39) == 0);
            rf = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 59) == 0)
                current_height = 10'($urandom_range(0, 130));
            step(ib, ge, ct, rf, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
